// File: rtl/scpu_mem_pkg.sv
// Shared definitions for the scratch-memory bus initiator: op encodings,
// sequencer states and default bus widths.
package scpu_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_FILL   = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

endpackage

// File: rtl/mem_fill_seq.sv
// Fill sequencer: current fill address (wrapping modulo 2^ADDR_W) and the
// remaining byte count. Only instantiated when MEM_MASTER_FILL_EN is defined.
module mem_fill_seq
    import scpu_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_len,
    output logic [ADDR_W-1:0] o_next_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_cnt;

    // A loaded length of 0 counts down through 255..1, giving 256 writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_addr <= i_addr;
            r_cnt  <= i_len;
        end else if (i_step) begin
            r_addr <= o_next_addr;
            r_cnt  <= r_cnt - 8'd1;
        end
    end

    assign o_next_addr = r_addr + ADDR_W'(1);
    assign o_last      = (r_cnt == 8'd1);

endmodule

// File: rtl/mem_master.sv
// Scratch-memory bus initiator: one command at a time, registered strobes,
// one-cycle response pulse. Define MEM_MASTER_FILL_EN to enable the fill op.
module mem_master
    import scpu_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [7:0]        cmd_len,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_ce,
    output logic              mem_r,
    output logic              mem_w,
    output logic              mem_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            r_state;
    logic              r_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_mem_ce;
    logic              r_mem_r;
    logic              r_mem_w;
    logic              r_mem_oe;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    op_e  w_op;
    logic w_accept;
    logic w_is_rw;

    assign w_op     = op_e'(cmd_op);
    assign w_accept = cmd_valid & r_ready;
    assign w_is_rw  = (w_op == OP_READ) || (w_op == OP_WRITE);

`ifdef MEM_MASTER_FILL_EN
    logic [ADDR_W-1:0] w_fill_next;
    logic              w_fill_last;

    mem_fill_seq #(.ADDR_W(ADDR_W)) u_fill_seq (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept && (w_op == OP_FILL)),
        .i_step      (r_state == ST_FILL),
        .i_addr      (cmd_addr),
        .i_len       (cmd_len),
        .o_next_addr (w_fill_next),
        .o_last      (w_fill_last)
    );
`else
    logic w_unused_len;
    assign w_unused_len = ^cmd_len;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_ce    <= 1'b0;
            r_mem_r     <= 1'b0;
            r_mem_w     <= 1'b0;
            r_mem_oe    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        if (w_is_rw) begin
                            r_state     <= ST_ACCESS;
                            r_mem_ce    <= 1'b1;
                            r_mem_r     <= (w_op == OP_READ);
                            r_mem_oe    <= (w_op == OP_READ);
                            r_mem_w     <= (w_op == OP_WRITE);
                            r_mem_addr  <= cmd_addr;
                            r_mem_wdata <= cmd_wdata;
`ifdef MEM_MASTER_FILL_EN
                        end else if (w_op == OP_FILL) begin
                            r_state     <= ST_FILL;
                            r_mem_ce    <= 1'b1;
                            r_mem_w     <= 1'b1;
                            r_mem_addr  <= cmd_addr;
                            r_mem_wdata <= cmd_wdata;
`endif
                        end else begin
                            // Reserved (or disabled) op: answer with an error, never touch memory.
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_mem_r) begin
                        r_rsp_rdata <= mem_rdata;
                    end
                    r_mem_ce    <= 1'b0;
                    r_mem_r     <= 1'b0;
                    r_mem_oe    <= 1'b0;
                    r_mem_w     <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_state     <= ST_RESP;
                end
`ifdef MEM_MASTER_FILL_EN
                ST_FILL: begin
                    if (w_fill_last) begin
                        r_mem_ce    <= 1'b0;
                        r_mem_w     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_mem_addr <= w_fill_next;
                    end
                end
`endif
                ST_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_ce    = r_mem_ce;
    assign mem_r     = r_mem_r;
    assign mem_w     = r_mem_w;
    assign mem_oe    = r_mem_oe;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
